// File: rtl/argminmax_stream.sv
// Streaming IEEE-754 min/max reduction that returns the extreme element, its global index and the beat count.
// Optional feature macro ARGMINMAX_NAN_EN: keep NaNs out of the selection and report them on out_nan.
module argminmax_stream #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    LANES     = 4,
    parameter int    MAX_BEATS = 16,
    localparam int   IDX_BITS  = (LANES * MAX_BEATS > 1) ? $clog2(LANES * MAX_BEATS) : 1,
    localparam int   BEAT_BITS = $clog2(MAX_BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic                 in_mode,
    input  logic [BITS-1:0]      vector_a [LANES],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS-1:0]      c,
    output logic [IDX_BITS-1:0]  out_index,
    output logic [BEAT_BITS-1:0] out_beats,
    output logic                 out_trunc,
    output logic                 out_nan
);

    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int P      = 1 << LEVELS;

`ifdef ARGMINMAX_NAN_EN
    localparam int EXP_W = (PRECISION == "DOUBLE") ? 11 : (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MAN_W = BITS - 1 - EXP_W;
    localparam logic [BITS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic is_nan(input logic [BITS-1:0] x);
        return (&x[BITS-2 -: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction
`endif

    // Unsigned key in IEEE value order; -0 folds onto +0 so they tie.
    function automatic logic [BITS-1:0] order_key(input logic [BITS-1:0] x);
        if (x[BITS-2:0] == '0) return {1'b1, {(BITS-1){1'b0}}};
        if (x[BITS-1])         return ~x;
        return {1'b1, x[BITS-2:0]};
    endfunction

    // Strictly-better test: the held (lower-index) operand wins every tie.
    function automatic logic cand_wins(input logic [BITS-1:0] held, input logic [BITS-1:0] cand,
                                       input logic mode);
`ifdef ARGMINMAX_NAN_EN
        if (is_nan(cand)) return 1'b0;
        if (is_nan(held)) return 1'b1;
`endif
        return mode ? (order_key(cand) > order_key(held)) : (order_key(cand) < order_key(held));
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic                 mode;
        logic                 trunc;
        logic                 nan;
        logic [BEAT_BITS-1:0] beats;
    } side_t;

    logic                 en, accept;
    logic                 first_q, first_d, mode_q, mode_d;
    logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d, beat_num;
    logic [IDX_BITS-1:0]  base_q, base_d, this_base;
    logic                 beat_full, beat_mode, beat_nan;
    side_t                leaf_side, tail;
    side_t                sv     [LEVELS+1];
    side_t                side_q [LEVELS+1];
    side_t                side_d [LEVELS+1];
    logic [BITS-1:0]      hv [2*P];
    logic [IDX_BITS-1:0]  hi [2*P];
    logic [BITS-1:0]      node_val_q [P];
    logic [BITS-1:0]      node_val_d [P];
    logic [IDX_BITS-1:0]  node_idx_q [P];
    logic [IDX_BITS-1:0]  node_idx_d [P];
    logic [BITS-1:0]      acc_val_q, acc_val_d, merged_val;
    logic [IDX_BITS-1:0]  acc_idx_q, acc_idx_d, merged_idx;
    logic                 acc_nan_q, acc_nan_d, merged_nan, take_root;
    logic                 out_valid_q, out_valid_d, out_trunc_q, out_trunc_d, out_nan_q, out_nan_d;
    logic [BITS-1:0]      c_q, c_d;
    logic [IDX_BITS-1:0]  out_index_q, out_index_d;
    logic [BEAT_BITS-1:0] out_beats_q, out_beats_d;

    // NOTE: every *_d gets its hold value first, so no path through a combinational block leaves it unassigned.
    always_comb begin
        en        = !out_valid_q || out_ready;
        in_ready  = en && rstn;
        accept    = in_valid && in_ready;
        beat_num  = first_q ? BEAT_BITS'(1) : beat_cnt_q + BEAT_BITS'(1);
        this_base = first_q ? '0 : base_q;
        beat_full = (beat_num == BEAT_BITS'(MAX_BEATS));
        beat_mode = first_q ? in_mode : mode_q;
        beat_nan  = 1'b0;
`ifdef ARGMINMAX_NAN_EN
        for (int k = 0; k < LANES; k++) beat_nan = beat_nan | is_nan(vector_a[k]);
`endif
        leaf_side = '{valid: accept, first: first_q, last: in_last || beat_full, mode: beat_mode,
                      trunc: beat_full && !in_last, nan: beat_nan, beats: beat_num};
        first_d    = first_q;
        mode_d     = mode_q;
        beat_cnt_d = beat_cnt_q;
        base_d     = base_q;
        if (accept) begin
            first_d    = in_last || beat_full;
            mode_d     = beat_mode;
            beat_cnt_d = beat_num;
            base_d     = this_base + IDX_BITS'(LANES);
        end
    end

    // Heap-ordered tree: node 1 is the root, leaves sit at P..2P-1, padding repeats the last lane.
    always_comb begin
        sv[0]      = leaf_side;
        side_d     = side_q;
        node_val_d = node_val_q;
        node_idx_d = node_idx_q;
        for (int l = 1; l <= LEVELS; l++) begin
            sv[l]     = side_q[l];
            side_d[l] = en ? sv[l-1] : side_q[l];
        end
        hv[0] = '0;
        hi[0] = '0;
        for (int n = 1; n < P; n++) begin
            hv[n] = node_val_q[n];
            hi[n] = node_idx_q[n];
        end
        for (int k = 0; k < P; k++) begin
            hv[P+k] = vector_a[(k < LANES) ? k : LANES-1];
            hi[P+k] = this_base + IDX_BITS'((k < LANES) ? k : LANES-1);
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int n = P >> l; n < (P >> (l-1)); n++) begin
                if (en) begin
                    if (cand_wins(hv[2*n], hv[2*n+1], sv[l-1].mode)) begin
                        node_val_d[n] = hv[2*n+1];
                        node_idx_d[n] = hi[2*n+1];
                    end else begin
                        node_val_d[n] = hv[2*n];
                        node_idx_d[n] = hi[2*n];
                    end
                end
            end
        end
    end

    always_comb begin
        tail        = sv[LEVELS];
        take_root   = tail.first || cand_wins(acc_val_q, hv[1], tail.mode);
        merged_val  = take_root ? hv[1] : acc_val_q;
        merged_idx  = take_root ? hi[1] : acc_idx_q;
        merged_nan  = tail.nan || (!tail.first && acc_nan_q);
        acc_val_d   = acc_val_q;
        acc_idx_d   = acc_idx_q;
        acc_nan_d   = acc_nan_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        out_index_d = out_index_q;
        out_beats_d = out_beats_q;
        out_trunc_d = out_trunc_q;
        out_nan_d   = out_nan_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (tail.valid) begin
                acc_val_d = merged_val;
                acc_idx_d = merged_idx;
                acc_nan_d = merged_nan;
                if (tail.last) begin
                    out_valid_d = 1'b1;
                    c_d         = merged_val;
                    out_index_d = merged_idx;
                    out_beats_d = tail.beats;
                    out_trunc_d = tail.trunc;
                    out_nan_d   = merged_nan;
`ifdef ARGMINMAX_NAN_EN
                    if (is_nan(merged_val)) begin
                        c_d         = QNAN;
                        out_index_d = '0;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            first_q     <= 1'b1;
            mode_q      <= 1'b0;
            beat_cnt_q  <= '0;
            base_q      <= '0;
            side_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            c_q         <= '0;
            out_index_q <= '0;
            out_beats_q <= '0;
            out_trunc_q <= 1'b0;
            out_nan_q   <= 1'b0;
        end else begin
            first_q     <= first_d;
            mode_q      <= mode_d;
            beat_cnt_q  <= beat_cnt_d;
            base_q      <= base_d;
            side_q      <= side_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            out_index_q <= out_index_d;
            out_beats_q <= out_beats_d;
            out_trunc_q <= out_trunc_d;
            out_nan_q   <= out_nan_d;
        end
    end

    // NOTE: tree and accumulator data carry no reset; they are only read under a valid/first bit that is reset.
    always_ff @(posedge clk) begin
        node_val_q <= node_val_d;
        node_idx_q <= node_idx_d;
        acc_val_q  <= acc_val_d;
        acc_idx_q  <= acc_idx_d;
        acc_nan_q  <= acc_nan_d;
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign out_index = out_index_q;
    assign out_beats = out_beats_q;
    assign out_trunc = out_trunc_q;
    assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_argminmax_stream.sv
// Self-checking bench for argminmax_stream (HALF, LANES=4, MAX_BEATS=16): directed cases plus
// randomized vectors scored against a real-valued reference model.
module tb_argminmax_stream;

    localparam int LANES     = 4;
    localparam int MAX_BEATS = 16;

    typedef struct {
        logic [15:0] c;
        logic [5:0]  idx;
        logic [4:0]  beats;
        logic        trunc;
        logic        nan;
    } result_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_last, in_mode;
    logic [15:0] vector_a [LANES];
    logic        out_valid, out_ready;
    logic [15:0] c;
    logic [5:0]  out_index;
    logic [4:0]  out_beats;
    logic        out_trunc, out_nan;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          beat_taken;
    bit          rand_gaps, rand_ready;
    result_t     exp_q [$];
    logic [15:0] elems [$];
    int          cur_beats;
    bit          cur_mode;
    logic [15:0] last_c;
    logic [5:0]  last_idx;
    logic [4:0]  last_beats;
    logic        last_trunc;

    argminmax_stream dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_mode(in_mode), .vector_a(vector_a), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .out_index(out_index), .out_beats(out_beats), .out_trunc(out_trunc), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: numeric value order on decoded halves ----------------
    function automatic bit h_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 0);
    endfunction

    function automatic real h_rank(input logic [15:0] x);
        int  e = int'(x[14:10]);
        int  m = int'(x[9:0]);
        real mag;
        if (e == 31)     mag = (m == 0) ? 1.0e9 : 1.0e10 + m;
        else if (e == 0) mag = m * (2.0 ** (-24));
        else             mag = (1024 + m) * (2.0 ** (e - 25));
        return x[15] ? -mag : mag;
    endfunction

    function automatic bit model_better(input logic [15:0] cand, input logic [15:0] held, input bit mode);
`ifdef ARGMINMAX_NAN_EN
        if (h_is_nan(cand)) return 1'b0;
        if (h_is_nan(held)) return 1'b1;
`endif
        return mode ? (h_rank(cand) > h_rank(held)) : (h_rank(cand) < h_rank(held));
    endfunction

    task automatic model_finish(input bit trunc);
        result_t r;
        int best = 0;
        for (int i = 1; i < elems.size(); i++)
            if (model_better(elems[i], elems[best], cur_mode)) best = i;
        r.c   = elems[best];
        r.idx = 6'(best);
        r.nan = 1'b0;
`ifdef ARGMINMAX_NAN_EN
        foreach (elems[i]) if (h_is_nan(elems[i])) r.nan = 1'b1;
        if (h_is_nan(r.c)) begin
            r.c   = 16'h7E00;
            r.idx = 6'd0;
        end
`endif
        r.beats = 5'(cur_beats);
        r.trunc = trunc;
        exp_q.push_back(r);
    endtask

    task automatic model_beat(input logic [15:0] d [LANES], input bit last, input bit mode);
        if (cur_beats == 0) cur_mode = mode;
        cur_beats++;
        for (int k = 0; k < LANES; k++) elems.push_back(d[k]);
        if (last || cur_beats == MAX_BEATS) begin
            model_finish(!last);
            elems.delete();
            cur_beats = 0;
        end
    endtask

    task automatic model_reset();
        elems.delete();
        exp_q.delete();
        cur_beats = 0;
    endtask

    // ---------------- driver / monitor ----------------
    task automatic check_result();
        result_t e;
        if (exp_q.size() == 0) begin
            check("spurious_out_valid", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("res_c", c, e.c);
        check("res_index", out_index, e.idx);
        check("res_beats", out_beats, e.beats);
        check("res_trunc", out_trunc, e.trunc);
        check("res_nan", out_nan, e.nan);
        last_c     = c;
        last_idx   = out_index;
        last_beats = out_beats;
        last_trunc = out_trunc;
    endtask

    // Handshakes are judged on the falling edge, then inputs change 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        beat_taken = in_valid && in_ready;
        if (beat_taken) model_beat(vector_a, in_last, in_mode);
        if (out_valid && out_ready) check_result();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d [LANES], input bit last, input bit mode);
        int guard;
        if (rand_gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        in_valid = 1'b1;
        vector_a = d;
        in_last  = last;
        in_mode  = mode;
        guard    = 0;
        do begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            step();
            guard++;
        end while (!beat_taken && guard < 100);
        if (!beat_taken) check("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (4) step();
    endtask

    task automatic do_reset(input int cycles);
        rstn     = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        model_reset();
    endtask

    function automatic logic [15:0] gen_val();
        logic [15:0] pool [8] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00,
                                  16'h7C00, 16'hFC00, 16'h7E00, 16'h4000};
        if ($urandom_range(0, 9) < 4) return pool[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] b [LANES];
        int lat, guard, nb;
        bit trunc_case, m;

        rand_gaps  = 0;
        rand_ready = 0;
        in_last    = 0;
        in_mode    = 0;
        out_ready  = 0;
        foreach (vector_a[k]) vector_a[k] = '0;

        // reset values
        do_reset(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_index", out_index, 0);
        check("rst_beats", out_beats, 0);
        check("rst_trunc", out_trunc, 0);
        check("rst_nan", out_nan, 0);
        check("rst_in_ready", in_ready, 0);
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // single-beat min, latency, hold under stall
        b = '{16'h3C00, 16'hC000, 16'h3800, 16'h0000};
        send_beat(b, 1, 0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_cycles", lat, 3);
        check("tp1_c", c, 16'hC000);
        check("tp1_index", out_index, 1);
        check("tp1_beats", out_beats, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_c_hold", c, 16'hC000);
        end
        drain();

        // max over 3 beats, mode flip on beat 1 ignored
        b = '{16'h3C00, 16'h4000, 16'hC400, 16'h0000};
        send_beat(b, 0, 1);
        b = '{16'h4400, 16'hBC00, 16'h4800, 16'h3800};
        send_beat(b, 0, 0);
        b = '{16'h3000, 16'h4200, 16'h5000, 16'h7C00};
        send_beat(b, 1, 0);
        drain();
        check("tp2_c", last_c, 16'h7C00);
        check("tp2_index", last_idx, 11);
        check("tp2_beats", last_beats, 3);

        // signed-zero ties go to the lowest index
        b = '{16'h8000, 16'h0000, 16'h8000, 16'h3C00};
        send_beat(b, 1, 0);
        drain();
        check("tie_c", last_c, 16'h8000);
        check("tie_index", last_idx, 0);

        // truncation at MAX_BEATS, then beat 17 opens a new vector
        for (int i = 0; i < MAX_BEATS; i++) begin
            foreach (b[k]) b[k] = gen_val();
            send_beat(b, 0, 0);
        end
        b = '{16'h4000, 16'h3C00, 16'h4400, 16'h3800};
        send_beat(b, 1, 0);
        drain();
        check("after_trunc_beats", last_beats, 1);
        check("after_trunc_trunc", last_trunc, 0);
        check("after_trunc_index", last_idx, 3);

        // back-to-back vectors held off by out_ready=0 for 5 cycles
        out_ready = 1'b0;
        b = '{16'h4000, 16'h4400, 16'h3C00, 16'h4800};
        send_beat(b, 0, 1);
        b = '{16'h3800, 16'h4A00, 16'h3000, 16'h0000};
        send_beat(b, 1, 1);
        b = '{16'hC000, 16'hBC00, 16'hC400, 16'hB800};
        send_beat(b, 1, 0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_c_hold", c, exp_q[0].c);
            check("bp_index_hold", out_index, exp_q[0].idx);
        end
        drain();
        check("bp_second_c", last_c, 16'hC400);

        // NaN handling
        b = '{16'h7E00, 16'h4000, 16'h7E00, 16'h4400};
        send_beat(b, 1, 0);
        drain();
        check("nan_c", last_c, 16'h4000);
        check("nan_index", last_idx, 1);
        b = '{16'hFE00, 16'h7C01, 16'h7E00, 16'hFD00};
        send_beat(b, 1, 0);
        drain();

        // reset mid-vector discards partial state
        b = '{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        send_beat(b, 0, 0);
        send_beat(b, 0, 0);
        out_ready = 1'b1;
        do_reset(1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("midrst_no_out", out_valid, 0);
        end
        rstn = 1'b1;
        b = '{16'h4400, 16'h4200, 16'h4800, 16'h4200};
        send_beat(b, 1, 0);
        drain();
        check("midrst_c", last_c, 16'h4200);
        check("midrst_index", last_idx, 1);
        check("midrst_beats", last_beats, 1);

        // randomized vectors with random gaps and backpressure
        rand_gaps  = 1;
        rand_ready = 1;
        for (int v = 0; v < 40; v++) begin
            nb         = $urandom_range(1, MAX_BEATS);
            trunc_case = (nb == MAX_BEATS) && ($urandom_range(0, 1) == 1);
            m          = $urandom_range(0, 1);
            for (int i = 0; i < nb; i++) begin
                foreach (b[k]) b[k] = gen_val();
                send_beat(b, (i == nb - 1) && !trunc_case, (i == 0) ? m : bit'($urandom_range(0, 1)));
            end
        end
        rand_gaps  = 0;
        rand_ready = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
